// File: rtl/mu0_reg_stack.sv
// Parametrised LIFO register stack (WIDTH x DEPTH) with push, pop and replace; Q shows top-of-stack.
// Optional MU0_STACK_WRAP_EN: a push on a full stack overwrites the oldest entry instead of flagging Err.
module mu0_reg_stack #(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Push,
  input  logic             Pop,
  input  logic [WIDTH-1:0] D,
  input  logic             ClrErr,
  output logic [WIDTH-1:0] Q,
  output logic [CW-1:0]    Count,
  output logic             Empty,
  output logic             Full,
  output logic             Err
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               tp, tp_inc, tp_dec, tp_nxt, wr_addr;
  logic [CW-1:0]               cnt, cnt_nxt;
  logic                        err, err_set, err_nxt, wr_en;

  assign Empty = (cnt == '0);
  assign Full  = (cnt == CW'(DEPTH));
  assign Count = cnt;
  assign Err   = err;
  assign Q     = Empty ? '0 : mem[tp];

  always_comb begin
    // Explicit wrap so DEPTH need not be a power of two.
    tp_inc  = (tp == PW'(DEPTH - 1)) ? '0 : tp + 1'b1;
    tp_dec  = (tp == '0) ? PW'(DEPTH - 1) : tp - 1'b1;
    tp_nxt  = tp;
    cnt_nxt = cnt;
    wr_en   = 1'b0;
    wr_addr = tp;
    err_set = 1'b0;
    if (En) begin
      if (Push && Pop && !Empty) begin
        wr_en = 1'b1;
      end else if (Push) begin
        if (!Full) begin
          tp_nxt  = tp_inc;
          wr_addr = tp_inc;
          wr_en   = 1'b1;
          cnt_nxt = cnt + 1'b1;
        end else begin
`ifdef MU0_STACK_WRAP_EN
          tp_nxt  = tp_inc;
          wr_addr = tp_inc;
          wr_en   = 1'b1;
`else
          err_set = 1'b1;
`endif
        end
      end else if (Pop) begin
        if (!Empty) begin
          tp_nxt  = tp_dec;
          cnt_nxt = cnt - 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end
    end
    // A new error beats a simultaneous clear.
    err_nxt = err_set ? 1'b1 : ((En && ClrErr) ? 1'b0 : err);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mem <= '0;
      tp  <= PW'(DEPTH - 1);
      cnt <= '0;
      err <= 1'b0;
    end else begin
      tp  <= tp_nxt;
      cnt <= cnt_nxt;
      err <= err_nxt;
      if (wr_en) mem[wr_addr] <= D;
    end
  end

endmodule

// File: tb/tb_mu0_reg_stack.sv
// Scoreboard bench for mu0_reg_stack: a queue-based stack model predicts {Q,Count,Empty,Full,Err} after each edge.
module tb_mu0_reg_stack;
  localparam int W  = 12;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);
  localparam int VW = W + CW + 3;

  logic          Clk, Reset, En, Push, Pop, ClrErr;
  logic [W-1:0]  D;
  logic [W-1:0]  Q;
  logic [CW-1:0] Count;
  logic          Empty, Full, Err;

  mu0_reg_stack #(.WIDTH(W), .DEPTH(DP)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Push(Push), .Pop(Pop), .D(D),
    .ClrErr(ClrErr), .Q(Q), .Count(Count), .Empty(Empty), .Full(Full), .Err(Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  m[$];
  bit            merr = 1'b0;
  logic [VW-1:0] sb[$];
  logic [VW-1:0] exp_v, act_v;

  function automatic logic [VW-1:0] model_view();
    logic [W-1:0] q;
    q = (m.size() > 0) ? m[m.size()-1] : '0;
    return {q, CW'(m.size()), m.size() == 0, m.size() == DP, merr};
  endfunction

  function automatic logic [VW-1:0] dut_view();
    return {Q, Count, Empty, Full, Err};
  endfunction

  // Drive one operation for the next rising edge, update the model, queue the expectation.
  task automatic drive(input bit en, push, pop, clr, input logic [W-1:0] d);
    bit e;
    @(negedge Clk);
    En = en; Push = push; Pop = pop; ClrErr = clr; D = d;
    @(posedge Clk);
    #1;
    if (en) begin
      e = 1'b0;
      if (push && pop && m.size() > 0) m[m.size()-1] = d;
      else if (push) begin
        if (m.size() < DP) m.push_back(d);
        else begin
`ifdef MU0_STACK_WRAP_EN
          void'(m.pop_front());
          m.push_back(d);
`else
          e = 1'b1;
`endif
        end
      end else if (pop) begin
        if (m.size() > 0) void'(m.pop_back());
        else e = 1'b1;
      end
      if (e) merr = 1'b1;
      else if (clr) merr = 1'b0;
    end
    sb.push_back(model_view());
  endtask

  task automatic test_reset();
    sb.push_back(model_view());
    #1;
    exp_v = sb.pop_front(); act_v = dut_view(); checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL reset got %h want %h (Q,Count,Empty,Full,Err)", act_v, exp_v);
    end
    #1 Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 12'h101);
      exp_v = sb.pop_front(); act_v = dut_view(); checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL hold[%0d] got %h want %h", i, act_v, exp_v);
      end
    end
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] v[4] = '{12'h101, 12'h111, 12'h100, 12'h110};
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(1'b1, 1'b1, 1'b0, 1'b0, v[i]);
      else       drive(1'b1, 1'b0, 1'b1, 1'b0, '0);
      exp_v = sb.pop_front(); act_v = dut_view(); checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL fill_drain[%0d] got %h want %h", i, act_v, exp_v);
      end
    end
  endtask

  task automatic test_underflow();
    // pop on empty, 3 idles, clear, clear+pop on empty
    bit st_pop[6] = '{1, 0, 0, 0, 0, 1};
    bit st_clr[6] = '{0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, st_pop[i], st_clr[i], '0);
      exp_v = sb.pop_front(); act_v = dut_view(); checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL underflow[%0d] got %h want %h", i, act_v, exp_v);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, '0);
    exp_v = sb.pop_front(); act_v = dut_view(); checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL underflow_clr got %h want %h", act_v, exp_v);
    end
  endtask

  task automatic test_replace();
    bit           st_push[5] = '{1, 1, 0, 1, 0};
    bit           st_pop[5]  = '{0, 1, 1, 1, 1};
    logic [W-1:0] st_d[5]    = '{12'h011, 12'h001, 12'h000, 12'h0AA, 12'h000};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, st_push[i], st_pop[i], 1'b0, st_d[i]);
      exp_v = sb.pop_front(); act_v = dut_view(); checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL replace[%0d] got %h want %h", i, act_v, exp_v);
      end
    end
  endtask

  task automatic test_overflow();
    // fill, replace on full, overflow push, drain, clear
    bit           st_push[11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    bit           st_pop[11]  = '{0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0};
    bit           st_clr[11]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic [W-1:0] st_d[11]    = '{12'h101, 12'h111, 12'h100, 12'h110, 12'h110, 12'h0FF,
                                  0, 0, 0, 0, 0};
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, st_push[i], st_pop[i], st_clr[i], st_d[i]);
      exp_v = sb.pop_front(); act_v = dut_view(); checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL overflow[%0d] got %h want %h", i, act_v, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] v[3] = '{12'h0A1, 12'h0B2, 12'h0C3};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, v[i]);
      exp_v = sb.pop_front(); act_v = dut_view(); checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL async_fill[%0d] got %h want %h", i, act_v, exp_v);
      end
    end
    En = 1'b0;
    #2 Reset = 1'b0;
    m.delete();
    merr = 1'b0;
    sb.push_back(model_view());
    #1;
    exp_v = sb.pop_front(); act_v = dut_view(); checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL async_reset got %h want %h", act_v, exp_v);
    end
    #2 Reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 12'h123);
    exp_v = sb.pop_front(); act_v = dut_view(); checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL async_push got %h want %h", act_v, exp_v);
    end
  endtask

  initial begin
    Reset = 1'b0; En = 1'b0; Push = 1'b0; Pop = 1'b0; ClrErr = 1'b0; D = '0;
    test_reset();
    test_fill_drain();
    test_underflow();
    test_replace();
    test_overflow();
    test_async_reset();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
